inst_str_streamer: RTL and testbench
====================================

Name: inst_str_streamer

Overview:
- Sits directly downstream of the instruction-to-ASCII decoder in the debug display path.
- Accepts one fixed-width ASCII instruction string (19 chars, packed MSB-first: first char in the top byte) through a valid/ready handshake.
- Latches the string and emits it one character per beat to the VGA text-buffer write port, each with its target address.
- Decouples the combinational decoder from the text buffer's write bandwidth and backpressure.

Parameters:
- N_CHARS, 19, number of characters per string; input width is N_CHARS*8.
- ADDR_W, 12, text-buffer address width.
- SUB_CHAR, 8'h3F, replacement byte for non-printable characters ('?').

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  string and base address valid.
- in_ready  out  1  block can accept a string.
- in_str  in  N_CHARS*8  ASCII string; char 0 = in_str[N_CHARS*8-1 -: 8].
- in_base  in  ADDR_W  text-buffer address of char 0.
- out_valid  out  1  out_char/out_addr valid.
- out_ready  in  1  text buffer accepts the beat.
- out_char  out  8  character byte (filtered).
- out_addr  out  ADDR_W  write address.
- busy  out  1  transfer in progress (state SEND).
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Single clock (clk). Reset is synchronous and active-high (rst); it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_char=8'h00, out_addr=0, busy=0, done=0, idx=0, shift register=0.
- States:
  - IDLE: in_ready=1, out_valid=0, busy=0.
  - SEND: in_ready=0, out_valid=1, busy=1.
- IDLE→SEND on the edge where in_valid&&in_ready.
  - in_str is latched into the shift register and in_base into the base register; idx=0.
  - The first beat (out_valid=1, char 0) appears in the cycle after acceptance: 1-cycle latency.
- In SEND:
  - out_char = filter(shift register top byte).
  - out_addr = base + idx, truncated to ADDR_W (wraps modulo 2^ADDR_W).
- out_char and out_addr are registered. They must hold stable while out_valid && !out_ready; stall is unbounded.
- Beat accepted on an edge with out_valid&&out_ready:
  - If idx < N_CHARS-1: shift register shifts left 8 bits and idx increments; the next char is presented in the next cycle with no bubble.
  - If idx == N_CHARS-1: go to IDLE, and done=1 for exactly the following cycle.
- Filter: a byte < 8'h20 or > 8'h7E is replaced by SUB_CHAR. Bytes 8'h20..8'h7E pass unchanged.
- No overlap between strings:
  - in_ready=0 throughout SEND, so in_valid is ignored there.
  - A new string can be accepted in the cycle done is high (state is IDLE).
  - Minimum period between acceptances is N_CHARS+1 cycles.
- in_str/in_base changes after acceptance have no effect on the string in flight.
- Reset mid-transfer: on the rst edge, out_valid drops, the remaining chars are discarded, done is not pulsed, and the block returns to IDLE.
- rst has priority over all handshakes in the same cycle.
- out_ready while out_valid=0 is ignored.
- Exactly N_CHARS beats are issued per accepted string, including space characters; no trimming.

Test Plan:
1. Reset → check in_ready=1, out_valid=0, busy=0, done=0, out_char=00, out_addr=000.
2. Basic stream: in_str=" add x01,x02,x03   ", in_base=12'h050, out_ready held 1.
   - Expect 19 consecutive beats at addrs 050..062: chars 20,61,64,64,20,78,30,31,2C,…,20.
   - Expect done pulse in the cycle after the beat at addr 062; in_ready=0 throughout.
3. Backpressure: same string, out_ready=0 for 5 cycles at beat 3 (char 'd', addr 053).
   - out_char=64 and out_addr=053 must stay stable for those 5 cycles.
   - Stream resumes with 20 at 054; total 19 beats, no duplicates or drops.
4. Wrap and filter: in_base=12'hFFE, string with char1=8'h0A and char2=8'h80.
   - Expect addrs FFE, FFF, 000, 001…; beats 1 and 2 carry 3F.
5. Reset mid-stream: assert rst after beat 7 is accepted.
   - Next cycle: out_valid=0, busy=0, in_ready=1, no done.
   - A new string is then accepted and streamed from char 0.
6. Back-to-back: in_valid held 1 with string B queued behind A.
   - B is accepted in the done cycle of A; B's first beat appears the next cycle; in_valid is ignored while busy.

Source files
------------

// File: rtl/inst_str_streamer_if.sv
// rtl/inst_str_streamer_if.sv - string input and text-buffer write port bundle for inst_str_streamer
interface inst_str_streamer_if #(
   parameter int N_CHARS = 19,
   parameter int ADDR_W  = 12
);
   logic                   in_valid;
   logic                   in_ready;
   logic [N_CHARS*8-1:0]   in_str;
   logic [ADDR_W-1:0]      in_base;
   logic                   out_valid;
   logic                   out_ready;
   logic [7:0]             out_char;
   logic [ADDR_W-1:0]      out_addr;
   logic                   busy;
   logic                   done;

   // master: decoder/text-buffer side; slave: the streamer itself
   modport master (
      output in_valid, in_str, in_base, out_ready,
      input  in_ready, out_valid, out_char, out_addr, busy, done
   );

   modport slave (
      input  in_valid, in_str, in_base, out_ready,
      output in_ready, out_valid, out_char, out_addr, busy, done
   );
endinterface

// File: rtl/inst_str_streamer.sv
// rtl/inst_str_streamer.sv - latches one ASCII instruction string and streams it char by char to the text buffer
module inst_str_streamer #(
   parameter int          N_CHARS  = 19,
   parameter int          ADDR_W   = 12,
   parameter logic [7:0]  SUB_CHAR = 8'h3F
) (
   input  logic                   clk,
   input  logic                   rst,
   inst_str_streamer_if.slave     bus
);
   localparam int W     = N_CHARS * 8;
   localparam int IDX_W = $clog2(N_CHARS);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state;
   logic [W-1:0]        shift_q;
   logic [ADDR_W-1:0]   base_q;
   logic [IDX_W-1:0]    idx;

   function automatic logic [7:0] filter_char(input logic [7:0] b);
      return (b < 8'h20 || b > 8'h7E) ? SUB_CHAR : b;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         shift_q       <= '0;
         base_q        <= '0;
         idx           <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_char  <= 8'h00;
         bus.out_addr  <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  state         <= SEND;
                  shift_q       <= bus.in_str;
                  base_q        <= bus.in_base;
                  idx           <= '0;
                  bus.in_ready  <= 1'b0;
                  bus.out_valid <= 1'b1;
                  bus.busy      <= 1'b1;
                  bus.out_char  <= filter_char(bus.in_str[W-1 -: 8]);
                  bus.out_addr  <= bus.in_base;
               end
            end
            SEND: begin
               if (bus.out_ready) begin
                  if (idx == IDX_W'(N_CHARS - 1)) begin
                     state         <= IDLE;
                     bus.in_ready  <= 1'b1;
                     bus.out_valid <= 1'b0;
                     bus.busy      <= 1'b0;
                     bus.done      <= 1'b1;
                  end else begin
                     // present the following byte straight away so accepted beats run back to back
                     shift_q      <= {shift_q[W-9:0], 8'h00};
                     idx          <= idx + 1'b1;
                     bus.out_char <= filter_char(shift_q[W-9 -: 8]);
                     bus.out_addr <= base_q + ADDR_W'(idx) + ADDR_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_str_streamer.sv
// tb/tb_inst_str_streamer.sv - randomized and directed self-checking bench for inst_str_streamer
module tb_inst_str_streamer;
   localparam int N = 19;
   localparam int AW = 12;

   typedef struct packed {
      logic [7:0]    ch;
      logic [AW-1:0] ad;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   inst_str_streamer_if #(.N_CHARS(N), .ADDR_W(AW)) bus ();

   inst_str_streamer dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int    n_cmp  = 0;
   int    n_fail = 0;
   bit    chk_en = 1'b0;
   bit    rnd_ready = 1'b0;
   beat_t mq[$];
   beat_t log_q[$];
   logic  m_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference: an accepted string becomes a list of N filtered beats at base+i
   task automatic model_push(input logic [N*8-1:0] s, input logic [AW-1:0] base);
      for (int i = 0; i < N; i++) begin
         beat_t b;
         logic [7:0] c;
         c = s[(N-1-i)*8 +: 8];
         b.ch = (c inside {[8'h20:8'h7E]}) ? c : 8'h3F;
         b.ad = base + AW'(i);
         mq.push_back(b);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         if (mq.size() > 0) begin
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("out_char", 32'(bus.out_char), 32'(mq[0].ch));
            chk("out_addr", 32'(bus.out_addr), 32'(mq[0].ad));
            chk("busy", 32'(bus.busy), 32'd1);
            chk("in_ready", 32'(bus.in_ready), 32'd0);
         end else begin
            chk("out_valid", 32'(bus.out_valid), 32'd0);
            chk("busy", 32'(bus.busy), 32'd0);
            chk("in_ready", 32'(bus.in_ready), 32'd1);
         end
         chk("done", 32'(bus.done), 32'(m_done));
      end
      if (rst) begin
         mq.delete();
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (mq.size() > 0) begin
            if (bus.out_ready) begin
               log_q.push_back(mq[0]);
               void'(mq.pop_front());
               if (mq.size() == 0) m_done = 1'b1;
            end
         end else if (bus.in_valid) begin
            model_push(bus.in_str, bus.in_base);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 9) < 6);
   endtask

   task automatic send_str(input logic [N*8-1:0] s, input logic [AW-1:0] base, input bit keep);
      bit acc;
      acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_str   = s;
      bus.in_base  = base;
      for (int t = 0; t < 500 && !acc; t++) begin
         @(negedge clk);
         if (bus.in_ready) acc = 1'b1;
         step();
      end
      if (!keep) bus.in_valid = 1'b0;
      chk("accept_seen", 32'(acc), 32'd1);
   endtask

   task automatic wait_idle();
      bit got;
      got = 1'b0;
      for (int t = 0; t < 500 && !got; t++) begin
         @(negedge clk);
         if (bus.done) got = 1'b1;
         step();
      end
      chk("done_seen", 32'(got), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      logic [N*8-1:0] sa, sb, sc;
      bit got;
      sa = " add x01,x02,x03   ";
      sc = "xor x05,x06,x07    ";
      bus.in_valid = 1'b0;
      bus.in_str = '0;
      bus.in_base = '0;
      bus.out_ready = 1'b1;

      // 1: reset state
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_out_char", 32'(bus.out_char), 32'h00);
      chk("rst_out_addr", 32'(bus.out_addr), 32'h000);
      chk_en = 1'b1;
      step();

      // 2: basic stream
      log_q.delete();
      send_str(sa, 12'h050, 1'b0);
      wait_idle();
      chk("t2_beats", log_q.size(), 32'd19);
      if (log_q.size() == 19) begin
         chk("t2_ch0", 32'(log_q[0].ch), 32'h20);
         chk("t2_ch1", 32'(log_q[1].ch), 32'h61);
         chk("t2_ch8", 32'(log_q[8].ch), 32'h2C);
         chk("t2_ad0", 32'(log_q[0].ad), 32'h050);
         chk("t2_ad18", 32'(log_q[18].ad), 32'h062);
         chk("t2_ch18", 32'(log_q[18].ch), 32'h20);
      end

      // 3: backpressure at beat 3
      log_q.delete();
      bus.out_ready = 1'b0;
      send_str(sa, 12'h050, 1'b0);
      bus.out_ready = 1'b1;
      repeat (3) step();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_stall_char", 32'(bus.out_char), 32'h64);
         chk("t3_stall_addr", 32'(bus.out_addr), 32'h053);
         step();
      end
      bus.out_ready = 1'b1;
      wait_idle();
      chk("t3_beats", log_q.size(), 32'd19);
      if (log_q.size() == 19) begin
         chk("t3_ch3", 32'(log_q[3].ch), 32'h64);
         chk("t3_ch4", 32'(log_q[4].ch), 32'h20);
         chk("t3_ad4", 32'(log_q[4].ad), 32'h054);
      end

      // 4: address wrap and filter
      log_q.delete();
      sb = sa;
      sb[(N-2)*8 +: 8] = 8'h0A;
      sb[(N-3)*8 +: 8] = 8'h80;
      send_str(sb, 12'hFFE, 1'b0);
      wait_idle();
      chk("t4_beats", log_q.size(), 32'd19);
      if (log_q.size() == 19) begin
         chk("t4_ad0", 32'(log_q[0].ad), 32'hFFE);
         chk("t4_ch1", 32'(log_q[1].ch), 32'h3F);
         chk("t4_ad1", 32'(log_q[1].ad), 32'hFFF);
         chk("t4_ch2", 32'(log_q[2].ch), 32'h3F);
         chk("t4_ad2", 32'(log_q[2].ad), 32'h000);
         chk("t4_ad3", 32'(log_q[3].ad), 32'h001);
         chk("t4_ch3", 32'(log_q[3].ch), 32'h64);
      end

      // 5: reset after beat 7 accepted
      log_q.delete();
      send_str(sa, 12'h300, 1'b0);
      repeat (8) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
      chk("t5_done", 32'(bus.done), 32'd0);
      chk("t5_beats", log_q.size(), 32'd8);
      step();
      log_q.delete();
      send_str(sc, 12'h310, 1'b0);
      wait_idle();
      chk("t5b_beats", log_q.size(), 32'd19);
      if (log_q.size() == 19) begin
         chk("t5b_ch0", 32'(log_q[0].ch), 32'h78);
         chk("t5b_ad0", 32'(log_q[0].ad), 32'h310);
      end

      // 6: back-to-back, B queued behind A
      log_q.delete();
      send_str(sa, 12'h100, 1'b1);
      bus.in_str = sc;
      bus.in_base = 12'h200;
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge clk);
         if (bus.done) begin
            got = 1'b1;
            chk("t6_ready_in_done", 32'(bus.in_ready), 32'd1);
         end
         step();
      end
      chk("t6_done_seen", 32'(got), 32'd1);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t6_b_valid", 32'(bus.out_valid), 32'd1);
      chk("t6_b_char", 32'(bus.out_char), 32'h78);
      chk("t6_b_addr", 32'(bus.out_addr), 32'h200);
      step();
      wait_idle();
      chk("t6_beats", log_q.size(), 32'd38);
      if (log_q.size() == 38) chk("t6_ad19", 32'(log_q[19].ad), 32'h200);

      // randomized strings, bases, gaps and backpressure
      rnd_ready = 1'b1;
      for (int k = 0; k < 25; k++) begin
         logic [N*8-1:0] rs;
         for (int i = 0; i < N; i++) rs[i*8 +: 8] = 8'($urandom);
         send_str(rs, AW'($urandom), 1'b0);
         repeat ($urandom_range(0, 3)) step();
      end
      wait_idle();
      rnd_ready = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
